m2_cmd_sequencer: RTL and testbench
===================================

// Module: m2_cmd_sequencer
// PURPOSE
//  Byte-stream command front end for bus master 2. Consumes framed bytes from a UART receiver,
//  drives the master_interface simple port (maddr/mwdata/mwvalid/wen), waits for completion and
//  returns one response byte to a UART transmitter. Replaces testbench-driven master 2 stimulus.
// PARAMETERS
//  ADDR_WIDTH      16  master address width; must be <=16; frame address truncated to LSBs
//  DATA_WIDTH      8   master data width; must be 8 (one data byte per frame)
//  TIMEOUT_CYCLES  4096 completion watchdog limit, in clk cycles (only with M2_SEQ_TIMEOUT_EN)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous, active-high reset
//  rx_data   in   8   received byte
//  rx_valid  in   1   one-cycle strobe, rx_data valid
//  tx_data   out  8   response byte
//  tx_valid  out  1   response valid; held until tx_ready
//  tx_ready  in   1   transmitter accepts tx_data when tx_valid&tx_ready
//  maddr     out  ADDR_WIDTH  master address
//  mwdata    out  DATA_WIDTH  master write data
//  mwvalid   out  1   one-cycle transaction start pulse
//  wen       out  1   1 write, 0 read; stable from mwvalid until completion
//  mrdata    in   DATA_WIDTH  read data from master
//  mrvalid   in   1   read data strobe
//  mready    in   1   master idle/ready
//  busy      out  1   high in any state except IDLE
//  rx_drop   out  1   one-cycle pulse when a byte arrives and is discarded
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; address/data holding regs 0; watchdog 0.
//  Frames: write = 0x57, ADDR_H, ADDR_L, DATA; read = 0x52, ADDR_H, ADDR_L.
//  States: IDLE->ADDR_H->ADDR_L->(DATA if write)->ISSUE->WAIT->RESP->IDLE.
//  IDLE: rx byte 0x57/0x52 latches op, ->ADDR_H; any other byte ignored (no rx_drop, stays IDLE).
//  ADDR_H/ADDR_L/DATA: each advances on rx_valid, latching the byte; no inter-byte timeout.
//  ISSUE: waits for mready=1; then mwvalid=1 for exactly one cycle with maddr={H,L}[ADDR_WIDTH-1:0],
//   mwdata, wen driven in that same cycle; ->WAIT next cycle. maddr/mwdata/wen held until RESP exits.
//  WAIT write: complete on first mready rising edge (0 then 1) seen after the issue cycle.
//  WAIT read: complete on mrvalid=1; mrdata captured that cycle (mready ignored).
//  Completion -> RESP next cycle; tx_data = 0x4B (write) or captured mrdata (read); tx_valid=1.
//  RESP: tx_data/tx_valid stable until tx_ready; on handshake tx_valid->0, ->IDLE same edge.
//  rx_valid in ISSUE/WAIT/RESP: byte discarded, rx_drop pulses that cycle; state unaffected.
//  mrvalid or mready edges outside WAIT: ignored.
//  Min latency: last frame byte -> mwvalid = 1 cycle (mready=1 in ISSUE).
//  rst asserted mid-frame or mid-transaction: immediate return to reset values; partial frame lost;
//   no response emitted for the aborted command.
// CONFIGURATION
//  M2_SEQ_TIMEOUT_EN defined: watchdog counts cycles in WAIT; reaching TIMEOUT_CYCLES forces RESP
//   with tx_data=0xEE; counter clears on entering WAIT. A completion in the same cycle as the
//   timeout takes priority (normal response).
//  M2_SEQ_TIMEOUT_EN undefined: no counter; WAIT persists until completion; 0xEE never produced.
// TESTING
//  1 Write: rx 57,01,23,A5, mready=1 -> one mwvalid pulse, maddr=0x0123, mwdata=A5, wen=1;
//    mready 0 for 5 cycles then 1 -> tx_valid with tx_data=0x4B.
//  2 Read: rx 52,02,10; mrvalid pulse with mrdata=3C 8 cycles after issue -> tx_data=0x3C, wen=0.
//  3 Junk: rx 00,FF,4B in IDLE -> no mwvalid, busy=0, rx_drop=0; then valid write frame works.
//  4 Backpressure/drop: tx_ready=0 for 10 cycles in RESP, rx byte 57 sent -> tx_data stable,
//    rx_drop pulses once, returns IDLE after tx_ready=1 with no new command started.
//  5 Timeout (M2_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64): read issued, no mrvalid -> tx_data=0xEE
//    exactly 64 cycles after entering WAIT; without macro, still busy after 1000 cycles.
//  6 Reset: rst pulse after 52,02 received -> outputs 0, IDLE; following 52,00,04 reads 0x0004.

Source files
------------

// File: rtl/m2_cmd_sequencer.sv
// Byte-stream command front end for bus master 2: framed UART bytes in, one master
// transaction out, one response byte back. Optional completion watchdog: M2_SEQ_TIMEOUT_EN.
module m2_cmd_sequencer #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [ADDR_WIDTH-1:0] maddr,
   output logic [DATA_WIDTH-1:0] mwdata,
   output logic                  mwvalid,
   output logic                  wen,
   input  logic [DATA_WIDTH-1:0] mrdata,
   input  logic                  mrvalid,
   input  logic                  mready,
   output logic                  busy,
   output logic                  rx_drop
);

   // state  | meaning
   // IDLE   | hunting for an opcode byte (0x57 write, 0x52 read)
   // ADDR_H | waiting for address high byte
   // ADDR_L | waiting for address low byte
   // DATA   | waiting for write data byte
   // ISSUE  | frame complete, waiting for mready to launch mwvalid
   // WAIT   | transaction in flight, waiting for completion
   // RESP   | response byte presented, waiting for tx_ready
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR_H = 3'd1,
      ADDR_L = 3'd2,
      DATA   = 3'd3,
      ISSUE  = 3'd4,
      WAIT   = 3'd5,
      RESP   = 3'd6
   } state_t;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RESP_OK = 8'h4B;
   localparam logic [7:0] RESP_TO = 8'hEE;

   state_t                state_q, state_d;
   logic                  op_wr_q;
   logic [7:0]            addr_h_q, addr_l_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [7:0]            resp_q;
   logic                  mready_q;
   logic                  complete, timeout;
   logic [15:0]           addr_full;

   // Write completion is an mready rise; mready_q holds 1 from the issue cycle.
   assign complete = (state_q == WAIT) &&
                     (op_wr_q ? (mready && !mready_q) : mrvalid);

`ifdef M2_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;

   // Loaded on the issue edge so terminal count lands exactly TIMEOUT_CYCLES into WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (state_q == ISSUE && mready) begin
         wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if (state_q == WAIT && wd_q != '0) begin
         wd_q <= wd_q - 1'b1;
      end
   end

   assign timeout = (state_q == WAIT) && (wd_q == '0);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) state_d = ADDR_H;
         ADDR_H: if (rx_valid) state_d = ADDR_L;
         ADDR_L: if (rx_valid) state_d = op_wr_q ? DATA : ISSUE;
         DATA:   if (rx_valid) state_d = ISSUE;
         ISSUE:  if (mready) state_d = WAIT;
         WAIT:   if (complete || timeout) state_d = RESP;
         RESP:   if (tx_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE);
      mwvalid  = (state_q == ISSUE) && mready;
      tx_valid = (state_q == RESP);
      rx_drop  = rx_valid &&
                 (state_q == ISSUE || state_q == WAIT || state_q == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_wr_q  <= 1'b0;
         addr_h_q <= '0;
         addr_l_q <= '0;
         data_q   <= '0;
         resp_q   <= '0;
         mready_q <= 1'b0;
      end else begin
         mready_q <= mready;
         if (state_q == IDLE && rx_valid && (rx_data == OP_WR || rx_data == OP_RD))
            op_wr_q <= (rx_data == OP_WR);
         if (state_q == ADDR_H && rx_valid) addr_h_q <= rx_data;
         if (state_q == ADDR_L && rx_valid) addr_l_q <= rx_data;
         if (state_q == DATA && rx_valid)   data_q   <= rx_data[DATA_WIDTH-1:0];
         // A real completion wins over a coincident watchdog expiry.
         if (complete)
            resp_q <= op_wr_q ? RESP_OK : mrdata[7:0];
         else if (timeout)
            resp_q <= RESP_TO;
      end
   end

   assign addr_full = {addr_h_q, addr_l_q};
   assign maddr     = addr_full[ADDR_WIDTH-1:0];
   assign mwdata    = data_q;
   assign wen       = op_wr_q;
   assign tx_data   = resp_q;

endmodule

// File: tb/tb_m2_cmd_sequencer.sv
// Directed self-checking bench for m2_cmd_sequencer; expected values hand-derived from the
// frame format and cycle timing.
module tb_m2_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] maddr;
   logic [7:0]  mwdata;
   logic        mwvalid;
   logic        wen;
   logic [7:0]  mrdata;
   logic        mrvalid;
   logic        mready;
   logic        busy;
   logic        rx_drop;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   m2_cmd_sequencer #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .maddr(maddr), .mwdata(mwdata), .mwvalid(mwvalid), .wen(wen),
      .mrdata(mrdata), .mrvalid(mrvalid), .mready(mready),
      .busy(busy), .rx_drop(rx_drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] held;
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
      mrdata = 8'h00; mrvalid = 1'b0; mready = 1'b1;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_mwvalid", mwvalid, 0);
      chk("rst_maddr", maddr, 0);
      chk("rst_mwdata", mwdata, 0);
      chk("rst_wen", wen, 0);
      chk("rst_rx_drop", rx_drop, 0);
      rst = 1'b0;
      step();

      // 1: write 57 01 23 A5
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h23);
      rx_data = 8'hA5; rx_valid = 1'b1;
      #1 chk("t1_drop_in_frame", rx_drop, 0);
      step(); rx_valid = 1'b0;
      chk("t1_mwvalid", mwvalid, 1);
      chk("t1_maddr", maddr, 16'h0123);
      chk("t1_mwdata", mwdata, 8'hA5);
      chk("t1_wen", wen, 1);
      step();
      mready = 1'b0;
      #1 chk("t1_mwvalid_once", mwvalid, 0);
      repeat (4) step();
      chk("t1_waiting", tx_valid, 0);
      step();
      mready = 1'b1;
      #1 chk("t1_no_reissue", mwvalid, 0);
      chk("t1_wen_held", wen, 1);
      step();
      chk("t1_tx_valid", tx_valid, 1);
      chk("t1_tx_data", tx_data, 8'h4B);
      chk("t1_maddr_held", maddr, 16'h0123);
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      chk("t1_tx_valid_low", tx_valid, 0);
      chk("t1_idle", busy, 0);

      // 2: read 52 02 10, mrvalid 8 cycles after issue; mready rise in WAIT is ignored
      send_byte(8'h52); send_byte(8'h02); send_byte(8'h10);
      chk("t2_mwvalid", mwvalid, 1);
      chk("t2_maddr", maddr, 16'h0210);
      chk("t2_wen", wen, 0);
      step();
      mready = 1'b0; step();
      mready = 1'b1; step();
      chk("t2_mready_ignored", tx_valid, 0);
      chk("t2_busy", busy, 1);
      repeat (5) step();
      mrvalid = 1'b1; mrdata = 8'h3C;
      step();
      mrvalid = 1'b0; mrdata = 8'h00;
      chk("t2_tx_valid", tx_valid, 1);
      chk("t2_tx_data", tx_data, 8'h3C);
      chk("t2_wen", wen, 0);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      chk("t2_idle", busy, 0);

      // 3: junk bytes in IDLE, then a good write
      foreach (held[i]) ; // keeps held declared use-free warnings away from loop vars
      rx_data = 8'h00; rx_valid = 1'b1;
      #1 chk("t3_drop_00", rx_drop, 0);
      step();
      rx_data = 8'hFF;
      #1 chk("t3_busy_00", busy, 0);
      step();
      rx_data = 8'h4B;
      #1 chk("t3_busy_ff", busy, 0);
      chk("t3_drop_ff", rx_drop, 0);
      step(); rx_valid = 1'b0;
      chk("t3_busy_4b", busy, 0);
      chk("t3_mwvalid", mwvalid, 0);
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h07); send_byte(8'h11);
      chk("t3_mwvalid_good", mwvalid, 1);
      chk("t3_maddr", maddr, 16'h0007);
      chk("t3_mwdata", mwdata, 8'h11);
      step();
      mready = 1'b0; step();
      mready = 1'b1; step();
      chk("t3_tx_valid", tx_valid, 1);
      chk("t3_tx_data", tx_data, 8'h4B);

      // 4: backpressure in RESP with a dropped byte
      held = tx_data;
      step(); step();
      rx_data = 8'h57; rx_valid = 1'b1;
      #1 chk("t4_rx_drop", rx_drop, 1);
      step(); rx_valid = 1'b0;
      #1 chk("t4_rx_drop_once", rx_drop, 0);
      repeat (7) step();
      chk("t4_tx_valid_held", tx_valid, 1);
      chk("t4_tx_data_stable", tx_data, held);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      chk("t4_idle", busy, 0);
      step();
      chk("t4_no_new_cmd", busy, 0);

      // 5: read with no mrvalid
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
      chk("t5_mwvalid", mwvalid, 1);
      step();
`ifdef M2_SEQ_TIMEOUT_EN
      repeat (63) step();
      chk("t5_not_yet", tx_valid, 0);
      step();
      chk("t5_to_valid", tx_valid, 1);
      chk("t5_to_data", tx_data, 8'hEE);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
`else
      repeat (1000) step();
      chk("t5_still_busy", busy, 1);
      chk("t5_no_resp", tx_valid, 0);
      mrvalid = 1'b1; mrdata = 8'h5A;
      step();
      mrvalid = 1'b0;
      chk("t5_late_data", tx_data, 8'h5A);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
`endif
      chk("t5_idle", busy, 0);

      // 6: reset mid-frame, then read 0x0004
      send_byte(8'h52); send_byte(8'h02);
      rst = 1'b1;
      #1 chk("t6_rst_busy", busy, 0);
      chk("t6_rst_maddr", maddr, 0);
      chk("t6_rst_tx_data", tx_data, 0);
      chk("t6_rst_tx_valid", tx_valid, 0);
      step();
      rst = 1'b0;
      step();
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h04);
      chk("t6_maddr", maddr, 16'h0004);
      chk("t6_mwvalid", mwvalid, 1);
      step();
      mrvalid = 1'b1; mrdata = 8'h04;
      step();
      mrvalid = 1'b0;
      chk("t6_tx_valid", tx_valid, 1);
      chk("t6_tx_data", tx_data, 8'h04);
      tx_ready = 1'b1; step(); tx_ready = 1'b0;
      chk("t6_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
